// File: rtl/xlr8_dm_copy_engine.sv
// Block-copy bus master for the AVR data memory, sharing the DM port via bus_req/bus_gnt.
// Define XLR8_DM_COPY_FILL_EN to compile in constant-byte fill (fill_mode/fill_data).
module xlr8_dm_copy_engine #(
   parameter int DM_ADDR_W = 16
) (
   input  logic        cp2,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] src_addr,
   input  logic [15:0] dst_addr,
   input  logic [15:0] len,
   input  logic        fill_mode,
   input  logic [7:0]  fill_data,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [15:0] cnt_rem,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic        dm_ce,
   output logic        dm_we,
   output logic [15:0] dm_address,
   output logic [7:0]  dm_din,
   input  logic [7:0]  dm_dout,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q;
   logic [DM_ADDR_W-1:0] src_q;
   logic [DM_ADDR_W-1:0] dst_q;
   logic [15:0]          cnt_q;
   logic [7:0]           rdata_q;
   logic                 first_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 fill_sel;
   logic                 fill_start;
   logic [7:0]           wr_byte;

`ifdef XLR8_DM_COPY_FILL_EN
   logic                 fill_q;
   logic [7:0]           fill_data_q;
   assign fill_sel   = fill_q;
   assign fill_start = fill_mode;
`else
   logic                 unused_fill;
   assign unused_fill = ^{fill_mode, fill_data};
   assign fill_sel    = 1'b0;
   assign fill_start  = 1'b0;
`endif

   always_ff @(posedge cp2 or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         first_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef XLR8_DM_COPY_FILL_EN
         fill_q      <= 1'b0;
         fill_data_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  src_q  <= src_addr[DM_ADDR_W-1:0];
                  dst_q  <= dst_addr[DM_ADDR_W-1:0];
                  cnt_q  <= len;
                  busy_q <= 1'b1;
`ifdef XLR8_DM_COPY_FILL_EN
                  fill_q      <= fill_mode;
                  fill_data_q <= fill_data;
`endif
                  if (len == 16'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (fill_start) begin
                     state_q <= S_WR;
                  end else begin
                     state_q <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (bus_gnt) begin
                  src_q   <= src_q + DM_ADDR_W'(1);
                  first_q <= 1'b1;
                  state_q <= S_WR;
               end
            end
            S_WR: begin
               // Capture the read byte now so a stalled write ignores later dm_dout traffic.
               if (first_q) begin
                  rdata_q <= dm_dout;
                  first_q <= 1'b0;
               end
               if (bus_gnt) begin
                  dst_q <= dst_q + DM_ADDR_W'(1);
                  if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
               end
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (bus_gnt) begin
                  if (cnt_q == 16'd1) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (fill_sel) begin
                     state_q <= S_WR;
                  end else begin
                     state_q <= S_RD;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      wr_byte = first_q ? dm_dout : rdata_q;
`ifdef XLR8_DM_COPY_FILL_EN
      if (fill_q) wr_byte = fill_data_q;
`endif
      dm_ce      = 1'b0;
      dm_we      = 1'b0;
      dm_address = '0;
      dm_din     = '0;
      case (state_q)
         S_RD: begin
            dm_ce                       = bus_gnt;
            dm_address[DM_ADDR_W-1:0]   = src_q;
         end
         S_WR: begin
            dm_ce                       = bus_gnt;
            dm_we                       = bus_gnt;
            dm_address[DM_ADDR_W-1:0]   = dst_q;
            dm_din                      = wr_byte;
         end
         default: ;
      endcase
   end

   assign busy      = busy_q;
   assign bus_req   = busy_q;
   assign done      = done_q;
   assign cnt_rem   = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: doc/xlr8_dm_copy_engine.md
# xlr8_dm_copy_engine

Bus-master block-copy engine for the AVR data memory. It drives the same single-port DM interface the core uses: ce, 16-bit address, din, we, and dout registered by one cycle. It copies `len` bytes from `src_addr` to `dst_addr`, or fills a region with a constant byte when fill is compiled in. It sits beside the core behind the DM arbiter and requests the port with `bus_req`/`bus_gnt`.

## Interface
- `DM_ADDR_W`, default 16: width of the address registers and counters; DM address is `DM_ADDR_W` bits, zero-extended to 16.
- `cp2`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `src_addr`  in  16  first source byte address, latched on accepted start.
- `dst_addr`  in  16  first destination byte address, latched on accepted start.
- `len`  in  16  byte count; 0 = no-op.
- `fill_mode`  in  1  1 = fill instead of copy; honoured only with the macro.
- `fill_data`  in  8  fill byte, latched on accepted start.
- `abort`  in  1  cancel transfer; sampled every cycle while busy.
- `busy`  out  1  high from the cycle after an accepted start until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `cnt_rem`  out  16  bytes not yet written.
- `bus_req`  out  1  equal to `busy`.
- `bus_gnt`  in  1  arbiter grant; engine touches DM only in granted cycles.
- `dm_ce`, `dm_we`  out  1  DM clock enable / write enable.
- `dm_address`  out  16  DM address.
- `dm_din`  out  8  DM write data.
- `dm_dout`  in  8  DM read data; valid the cycle after the read address was presented.

## Operation
- States: IDLE, RD, WR, DONE. Register reset values: all states → IDLE; all registers and counters 0.
- Output reset values: `busy`, `done`, `bus_req`, `dm_ce` and `dm_we` are 0; `cnt_rem`, `dm_address` and `dm_din` are 0.
- IDLE:
  - `start`=1 and `len`≠0 → latch `src_addr`, `dst_addr`, `len` and `fill_data`; go to RD, or to WR in fill mode.
  - `start`=1 and `len`=0 → DONE.
  - `start` while not IDLE is ignored.
- RD:
  - `dm_ce`=`bus_gnt`, `dm_we`=0, `dm_address`=src.
  - With grant: src+1 and go to WR, with flag `first`=1. Without grant: hold RD.
- WR:
  - `dm_address`=dst, `dm_ce`=`dm_we`=`bus_gnt`.
  - `dm_din` = `dm_dout` when `first`=1, otherwise the captured `rdata`.
  - In the first WR cycle `rdata`←`dm_dout` unconditionally; `first` then clears. This makes a stalled write immune to other masters changing `dm_dout`.
  - With grant: dst+1, `cnt_rem`−1; go to DONE if `cnt_rem` was 1, else RD (WR in fill mode).
- DONE: `done`=1 for one cycle, then IDLE.
- Arithmetic: src/dst increment modulo 2^`DM_ADDR_W` (0xFFFF→0x0000 at default). `cnt_rem` never underflows.
- Copies are ascending, byte by byte. With overlapping regions and dst>src, already-written bytes are re-read; this is intended behaviour.
- Abort:
  - `abort`=1 in RD/WR/DONE → IDLE next edge, with no `done` pulse.
  - A write presented in the abort cycle with grant is committed.
  - `cnt_rem` holds the remaining count until the next start.
- `rst` mid-transfer: immediate IDLE; outputs go to reset values asynchronously.

## Timing
- `dm_ce`, `dm_we`, `dm_address` and `dm_din` are combinational from registered state and `bus_gnt`; everything else is registered.
- Start sampled at edge t0; `busy`/`bus_req` rise after t0.
- Copy with continuous grant:
  - Byte k is read in cycle t0+1+2k and written in cycle t0+2+2k.
  - `done` is high in cycle t0+1+2·len; `busy` falls after it.
- Fill: byte k is written in cycle t0+1+k; `done` in cycle t0+1+len.
- `len`=0: `done` and `busy` high in cycle t0+1 only; no DM access.
- Each non-granted cycle adds exactly one cycle of latency; no access is issued or lost.

## Configuration
- Macro `XLR8_DM_COPY_FILL_EN`.
- Defined: `fill_mode`=1 at start skips RD; WR drives latched `fill_data` at 1 byte/cycle.
- Undefined: `fill_mode` and `fill_data` are ignored, always copy, and no fill register is synthesized. Ports remain for integration.

## Test plan
- Copy, continuous grant: preload 0x100–0x103 = 11,22,33,44; src=0x100, dst=0x200, len=4 → 0x200–0x203 match. `done` in cycle t0+9; 8 DM accesses.
- Grant gaps: same copy with `bus_gnt` low in the first WR cycle and the core writing 0x100 meanwhile → dst still gets original 0x11. `done` delayed exactly by the number of denied cycles.
- Wrap and zero length: src=0xFFFF, dst=0x0300, len=2 → reads 0xFFFF then 0x0000. Separately, len=0 → `done` at t0+1 with `dm_ce` never high.
- Abort: len=10, assert `abort` during the 4th WR with grant → exactly 4 bytes written, no `done`, `cnt_rem`=6; a subsequent start runs normally.
- Async reset: assert `rst` mid-copy, between edges → `busy`, `bus_req`, `dm_ce` and `dm_we` drop without a clock edge.
- Fill (macro defined): fill_mode=1, fill_data=0xA5, dst=0x400, len=3 → 0x400–0x402 = A5 in cycles t0+1..t0+3, no reads. With the macro undefined, the same stimulus performs a copy.
